// File: rtl/y86_pkg.sv
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86 constants (icodes, stat codes, register ids) and
//               the pipeline-control state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

  localparam logic [3:0] c_ICODE_NOP    = 4'h1;
  localparam logic [3:0] c_ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] c_ICODE_JXX    = 4'h7;
  localparam logic [3:0] c_ICODE_RET    = 4'h9;
  localparam logic [3:0] c_ICODE_POPQ   = 4'hB;

  localparam logic [3:0] c_RNONE        = 4'hF;

  localparam logic [3:0] c_STAT_BUB     = 4'h0;
  localparam logic [3:0] c_STAT_AOK     = 4'h1;
  localparam logic [3:0] c_STAT_INS     = 4'h2;
  localparam logic [3:0] c_STAT_ADR     = 4'h3;
  localparam logic [3:0] c_STAT_HLT     = 4'h4;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic stat_is_exc(input logic [3:0] stat);
    return (stat == c_STAT_INS) || (stat == c_STAT_ADR) || (stat == c_STAT_HLT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_control.sv
// ============================================================================
// Module      : pipe_control
// Description : Y86 pipeline control: predicted-PC register, stall/bubble
//               generation, start/run/halt sequencing and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_control
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      f_predict_PC,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic [63:0]      F_Pred_PC,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic [3:0]       proc_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t           r_state;
  logic [63:0]      r_pred_pc;
  logic [3:0]       r_proc_stat;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;

  logic w_lu, w_rt, w_mp, w_ex, w_w_exc;

  assign w_lu    = ((E_icode == c_ICODE_MRMOVQ) || (E_icode == c_ICODE_POPQ)) &&
                   (E_dstM != c_RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_rt    = (D_icode == c_ICODE_RET) || (E_icode == c_ICODE_RET) ||
                   (M_icode == c_ICODE_RET);
  assign w_mp    = (E_icode == c_ICODE_JXX) && !e_Cnd;
  assign w_w_exc = stat_is_exc(W_stat);
  assign w_ex    = stat_is_exc(m_stat) || w_w_exc;

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    case (r_state)
      ST_START: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
      end
      ST_RUN: begin
        F_stall  = w_lu | w_rt;
        D_stall  = w_lu;
        // A pending load/use stall holds D, so the ret bubble waits for it
        D_bubble = w_mp | (w_rt & ~w_lu);
        E_bubble = w_mp | w_lu;
        M_bubble = w_ex;
        W_stall  = w_w_exc;
      end
      ST_HALT: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_START;
      r_pred_pc    <= RESET_PC;
      r_proc_stat  <= c_STAT_AOK;
      r_halted     <= 1'b0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (!F_stall)
        r_pred_pc <= f_predict_PC;
      case (r_state)
        ST_START: r_state <= ST_RUN;
        ST_RUN: begin
          r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
          if ((W_stat == c_STAT_AOK) && (W_icode != c_ICODE_NOP))
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
          if (w_w_exc) begin
            r_state     <= ST_HALT;
            r_proc_stat <= W_stat;
            r_halted    <= 1'b1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_START;
      endcase
    end
  end

  assign F_Pred_PC  = r_pred_pc;
  assign proc_stat  = r_proc_stat;
  assign halted     = r_halted;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire

// File: doc/pipe_control.md
# pipe_control

Pipeline control unit for the 5-stage Y86 processor. It owns the fetch pipeline register (F_Pred_PC) that feeds `fetch`, and it generates per-stage stall and bubble signals for load/use, `ret` and mispredicted-jump hazards. It runs a start-up/run/halt state machine that latches the architectural status, and it keeps cycle and retired-instruction counters. It sits beside the stage registers in the processor top level.

## Interface
- `RESET_PC`, 64'h0: value loaded into F_Pred_PC on reset.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `f_predict_PC` in 64: next-PC prediction from fetch.
- `D_icode` in 4: icode in the decode register.
- `E_icode` in 4: icode in the execute register.
- `M_icode` in 4: icode in the memory register.
- `W_icode` in 4: icode in the writeback register.
- `d_srcA` in 4: decode source register A.
- `d_srcB` in 4: decode source register B.
- `E_dstM` in 4: execute-stage memory destination register.
- `e_Cnd` in 1: jump condition evaluated in execute.
- `m_stat` in 4: memory-stage status.
- `W_stat` in 4: writeback-stage status.
- `F_Pred_PC` out 64: registered predicted PC, fed to `fetch`.
- `F_stall`, `D_stall`, `W_stall` out 1: hold the corresponding stage register.
- `D_bubble`, `E_bubble`, `M_bubble`, `W_bubble` out 1: load a bubble into the corresponding stage register.
- `proc_stat` out 4: architectural status.
- `halted` out 1: high in HALT.
- `cycle_cnt` out CNT_W: cycles spent in RUN.
- `retire_cnt` out CNT_W: instructions retired.

## Operation
- Constants:
  - icodes: NOP=1, MRMOVQ=5, JXX=7, RET=9, POPQ=B.
  - register none: RNONE=F.
  - stat: BUB=0, AOK=1, INS=2, ADR=3, HLT=4. A stat is exceptional when it is INS, ADR or HLT.
- Hazard terms, combinational:
  - `lu` = E_icode ∈ {MRMOVQ, POPQ} and E_dstM ≠ RNONE and E_dstM ∈ {d_srcA, d_srcB}.
  - `rt` = RET ∈ {D_icode, E_icode, M_icode}.
  - `mp` = E_icode = JXX and e_Cnd = 0.
  - `ex` = m_stat exceptional or W_stat exceptional.
- State machine states: START, RUN, HALT.
- START, the single cycle after reset release:
  - F_stall = 1, D_bubble = E_bubble = M_bubble = W_bubble = 1.
  - All other controls 0.
  - Next state RUN, unconditionally.
- RUN:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (rt & ~lu). D_stall has priority over D_bubble, so the two are never both high.
  - E_bubble = mp | lu.
  - M_bubble = ex.
  - W_stall = W_stat exceptional.
  - W_bubble = 0.
  - If W_stat is exceptional: next state HALT, and proc_stat ← W_stat.
- HALT (sticky until reset):
  - F_stall = D_stall = W_stall = 1, E_bubble = M_bubble = 1.
  - D_bubble = W_bubble = 0.
  - proc_stat holds its value.
- F_Pred_PC register: loads f_predict_PC on every edge where F_stall = 0, otherwise holds.
- Counters:
  - cycle_cnt increments on every RUN cycle.
  - retire_cnt increments in RUN when W_stat = AOK and W_icode ≠ NOP.
  - Both wrap modulo 2^CNT_W and freeze in START and HALT.

## Timing
- Reset values (asynchronous): state = START, F_Pred_PC = RESET_PC, proc_stat = AOK, halted = 0, both counters 0.
- Stall and bubble outputs are combinational from state and inputs, with zero latency; the stage registers sample them at the same edge.
- proc_stat and halted are registered and change one edge after an exceptional W_stat is seen in RUN.
- W_stat = BUB is not exceptional and does not count as a retire.
- Load/use together with ret: a stall (F, D) plus E bubble; the ret bubble is suppressed until the load clears.
- mp and lu cannot coexist, since E_icode is unique.
- rst_n asserted mid-operation: all registers are forced to reset values immediately. After release there is exactly one START cycle, then RUN.

## Structure
- Package `y86_pkg`: icode and stat localparams, RNONE, and a state enum (START/RUN/HALT). This package is shared with `fetch` and the other stages.
- A single module; no sub-module. The hazard terms are local wires, and the counters are inline.

## Test plan
- Reset release: for one cycle F_Pred_PC = 0, all four bubbles = 1 and F_stall = 1. On the next cycle the state is RUN and F_Pred_PC loads f_predict_PC = 0x0A.
- Load/use: E_icode = 5, E_dstM = 3, d_srcA = 3 → F_stall = D_stall = E_bubble = 1, D_bubble = 0, F_Pred_PC held. With E_dstM = F instead, no stall occurs.
- Ret: D_icode = 9 for 3 cycles (D, then E, then M) → F_stall = D_bubble = 1 in each cycle. When W_icode = 9, F_Pred_PC resumes loading.
- Mispredict: E_icode = 7, e_Cnd = 0 → D_bubble = E_bubble = 1 and F_stall = 0. With e_Cnd = 1, no control is asserted.
- Halt: m_stat = 4 → M_bubble = 1. On the next cycle W_stat = 4 → W_stall = 1, and after the edge halted = 1, proc_stat = 4 and the counters are frozen. W_stat = 3 then returns proc_stat = 3 in a separate run.
- Reset mid-run: with retire_cnt = 5 in RUN, rst_n pulses low → counters = 0, proc_stat = 1 and F_Pred_PC = RESET_PC immediately, followed by one START cycle.
